ras_ctrl: RTL and testbench

//  Return-address-stack controller; sits in the Fetch Unit directly upstream of call_stack.

---
 rtl/ras_pkg.sv | 41 ++++
 rtl/ras_cr_decode.sv | 31 +++
 rtl/ras_ctrl.sv | 130 +++++++++++++
 tb/tb_ras_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ras_pkg.sv
// Shared types and constants for the return-address-stack controller.
package ras_pkg;

  typedef enum logic [1:0] {
    CR_OTHER = 2'd0,
    CR_CALL  = 2'd1,
    CR_RET   = 2'd2
  } cr_type_t;

  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

  localparam logic [1:0] SPEC_NONE      = 2'b00;
  localparam logic [1:0] SPEC_ONE_CALL  = 2'b01;
  localparam logic [1:0] SPEC_CALL_CALL = 2'b10;
  localparam logic [1:0] SPEC_RET_CALL  = 2'b11;

  // Checkpoint pointer width tracks the call_stack depth; change RAS_DPT with it.
  localparam int RAS_DPT  = 8;
  localparam int RAS_PTRW = $clog2(RAS_DPT);

  typedef struct packed {
    logic                vld;
    cr_type_t            typ;
    logic [RAS_PTRW-1:0] ptr;
    logic                full;
  } ckpt_t;

  function automatic logic is_link(input logic [4:0] r);
    return (r == 5'd1) || (r == 5'd5);
  endfunction

  // t1 is the older (DU->EXU) slot, t0 the younger (FU->DU) slot.
  function automatic logic [1:0] spec_code(input cr_type_t t1, input cr_type_t t0);
    if (t1 == CR_CALL && t0 == CR_CALL) return SPEC_CALL_CALL;
    if (t1 == CR_RET && t0 == CR_CALL) return SPEC_RET_CALL;
    if (t1 == CR_CALL || t0 == CR_CALL) return SPEC_ONE_CALL;
    return SPEC_NONE;
  endfunction

endpackage

// File: rtl/ras_cr_decode.sv
// Combinational CALL/RET/OTHER classifier for RV32I jump instructions.
module ras_cr_decode
  import ras_pkg::*;
(
  input  logic        valid,
  input  logic [31:0] instr,
  output cr_type_t    cr_type
);

  logic [6:0] opc;
  logic       rd_link;
  logic       rs1_link;
  logic       is_jump;
  logic       unused_bits;

  assign opc         = instr[6:0];
  assign rd_link     = is_link(instr[11:7]);
  assign rs1_link    = is_link(instr[19:15]);
  assign is_jump     = (opc == OPC_JAL) || (opc == OPC_JALR);
  assign unused_bits = ^{instr[31:20], instr[14:12]};

  // rd=link wins over rs1=link, so a link-to-link JALR is a CALL.
  always_comb begin
    cr_type = CR_OTHER;
    if (valid && is_jump && rd_link)
      cr_type = CR_CALL;
    else if (valid && opc == OPC_JALR && rs1_link)
      cr_type = CR_RET;
  end

endmodule

// File: rtl/ras_ctrl.sv
// Return-address-stack controller: drives call_stack push/pop, RET prediction and flush rollback.
// Optional saturating statistics counters are built when RAS_CTRL_STATS_EN is defined.
module ras_ctrl
  import ras_pkg::*;
#(
  parameter  int DPT  = RAS_DPT,
  parameter  int DW   = 32,
  localparam int PTRW = $clog2(DPT)
) (
  input  logic            clk,
  input  logic            areset,
  input  logic            i_fu_valid,
  input  logic [31:0]     i_fu_instr,
  input  logic [DW-1:0]   i_fu_pc,
  input  logic            i_stall,
  input  logic            i_flush,
  input  logic [PTRW-1:0] i_stack_ptr,
  input  logic            i_stack_full,
  input  logic            i_stack_empty,
  input  logic [DW-1:0]   i_pop_data,
  output logic            o_push_en,
  output logic [DW-1:0]   o_push_data,
  output logic            o_pop_en,
  output logic            o_ret_pred_valid,
  output logic [DW-1:0]   o_ret_pred_target,
  output logic            o_rbk_en,
  output logic [PTRW-1:0] o_rbk_ptr,
  output logic            o_rbk_full,
  output logic            o_rbk_incr_ptr,
  output logic [1:0]      o_spec_state
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [31:0]     o_stat_calls,
  output logic [31:0]     o_stat_rets,
  output logic [31:0]     o_stat_rbks,
  output logic [31:0]     o_stat_empty_rets
`endif
);

  cr_type_t   fu_type;
  ckpt_t      s0;
  ckpt_t      s1;
  logic [1:0] blk_cnt;
  logic       accept;
  logic       s0_cr;
  logic       s1_cr;
  cr_type_t   s0_type;
  cr_type_t   s1_type;

  ras_cr_decode u_decode (
    .valid   (i_fu_valid),
    .instr   (i_fu_instr),
    .cr_type (fu_type)
  );

  // Reset is in the accept term so the comb outputs read 0 while it is held.
  assign accept = i_fu_valid & ~i_stall & ~i_flush & (blk_cnt == 2'd0) & ~areset;

  assign o_push_en         = accept & (fu_type == CR_CALL);
  assign o_pop_en          = accept & (fu_type == CR_RET) & ~i_stack_empty;
  assign o_ret_pred_valid  = o_pop_en;
  assign o_push_data       = areset ? '0 : i_fu_pc + DW'(4);
  assign o_ret_pred_target = areset ? '0 : i_pop_data;
  assign o_rbk_incr_ptr    = 1'b0;

  assign s0_type = s0.vld ? s0.typ : CR_OTHER;
  assign s1_type = s1.vld ? s1.typ : CR_OTHER;
  assign s0_cr   = s0_type != CR_OTHER;
  assign s1_cr   = s1_type != CR_OTHER;

  assign o_spec_state = spec_code(s1_type, s0_type);

  // The older slot holds the earliest pre-op pointer, so it is the restore point.
  always_comb begin
    o_rbk_en   = 1'b0;
    o_rbk_ptr  = '0;
    o_rbk_full = 1'b0;
    if (i_flush && (s1_cr || s0_cr)) begin
      o_rbk_en   = 1'b1;
      o_rbk_ptr  = s1_cr ? s1.ptr : s0.ptr;
      o_rbk_full = s1_cr ? s1.full : s0.full;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s0      <= '0;
      s1      <= '0;
      blk_cnt <= '0;
    end else if (i_flush) begin
      s0      <= '0;
      s1      <= '0;
      blk_cnt <= 2'd2;
    end else begin
      if (blk_cnt != 2'd0)
        blk_cnt <= blk_cnt - 2'd1;
      if (!i_stall) begin
        s1 <= s0;
        if (accept)
          s0 <= '{vld: 1'b1, typ: fu_type, ptr: i_stack_ptr, full: i_stack_full};
        else
          s0 <= '0;
      end
    end
  end

`ifdef RAS_CTRL_STATS_EN
  logic empty_ret;
  assign empty_ret = accept & (fu_type == CR_RET) & i_stack_empty;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      o_stat_calls      <= '0;
      o_stat_rets       <= '0;
      o_stat_rbks       <= '0;
      o_stat_empty_rets <= '0;
    end else begin
      if (o_push_en && o_stat_calls != '1)
        o_stat_calls <= o_stat_calls + 32'd1;
      if (o_pop_en && o_stat_rets != '1)
        o_stat_rets <= o_stat_rets + 32'd1;
      if (o_rbk_en && o_stat_rbks != '1)
        o_stat_rbks <= o_stat_rbks + 32'd1;
      if (empty_ret && o_stat_empty_rets != '1)
        o_stat_empty_rets <= o_stat_empty_rets + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Scoreboard bench for ras_ctrl: stimulus queues expected push/pop/rollback events, a monitor checks them.
module tb_ras_ctrl;

  localparam logic [31:0] JAL_X1    = 32'h000000EF;
  localparam logic [31:0] JAL_X0    = 32'h0000006F;
  localparam logic [31:0] RET_X1    = 32'h00008067;
  localparam logic [31:0] RET_X5    = 32'h00028067;
  localparam logic [31:0] JALR_X1X1 = 32'h000080E7;
  localparam logic [31:0] JALR_X5X1 = 32'h000082E7;
  localparam logic [31:0] ADDI_X1   = 32'h00100093;

  logic        clk = 1'b0;
  logic        areset;
  logic        fu_valid;
  logic [31:0] fu_instr;
  logic [31:0] fu_pc;
  logic        stall;
  logic        flush;
  logic [2:0]  sptr;
  logic        sfull;
  logic        sempty;
  logic [31:0] pdata;
  logic        push_en;
  logic [31:0] push_data;
  logic        pop_en;
  logic        pred_valid;
  logic [31:0] pred_target;
  logic        rbk_en;
  logic [2:0]  rbk_ptr;
  logic        rbk_full;
  logic        rbk_incr;
  logic [1:0]  spec_state;

  always #5 clk = ~clk;

  ras_ctrl #(.DPT(8), .DW(32)) dut (
    .clk               (clk),
    .areset            (areset),
    .i_fu_valid        (fu_valid),
    .i_fu_instr        (fu_instr),
    .i_fu_pc           (fu_pc),
    .i_stall           (stall),
    .i_flush           (flush),
    .i_stack_ptr       (sptr),
    .i_stack_full      (sfull),
    .i_stack_empty     (sempty),
    .i_pop_data        (pdata),
    .o_push_en         (push_en),
    .o_push_data       (push_data),
    .o_pop_en          (pop_en),
    .o_ret_pred_valid  (pred_valid),
    .o_ret_pred_target (pred_target),
    .o_rbk_en          (rbk_en),
    .o_rbk_ptr         (rbk_ptr),
    .o_rbk_full        (rbk_full),
    .o_rbk_incr_ptr    (rbk_incr),
    .o_spec_state      (spec_state)
  );

  typedef struct packed {
    logic        push;
    logic [31:0] pdat;
    logic        pop;
    logic [31:0] tgt;
    logic        rbk;
    logic [2:0]  rptr;
    logic        rfull;
    logic [1:0]  spec;
  } ev_t;

  ev_t sbq[$];
  ev_t mexp;
  int  vectors = 0;
  int  miscompares = 0;
  int  ev_idx = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic push, input logic [31:0] pd, input logic pop,
                           input logic [31:0] tg, input logic rbk, input logic [2:0] rp,
                           input logic rf, input logic [1:0] sp);
    ev_t e;
    e.push = push; e.pdat = pd; e.pop = pop; e.tgt = tg;
    e.rbk = rbk; e.rptr = rp; e.rfull = rf; e.spec = sp;
    sbq.push_back(e);
  endtask

  task automatic exp_push(input logic [31:0] pd, input logic [1:0] sp);
    expect_ev(1'b1, pd, 1'b0, 32'h0, 1'b0, 3'd0, 1'b0, sp);
  endtask

  task automatic exp_pop(input logic [31:0] tg, input logic [1:0] sp);
    expect_ev(1'b0, 32'h0, 1'b1, tg, 1'b0, 3'd0, 1'b0, sp);
  endtask

  task automatic exp_rbk(input logic [2:0] rp, input logic rf, input logic [1:0] sp);
    expect_ev(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, rp, rf, sp);
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic st, input logic fl);
    fu_valid = v; fu_instr = ins; fu_pc = pc; stall = st; flush = fl;
    #1;
  endtask

  task automatic stack(input logic [2:0] p, input logic f, input logic e, input logic [31:0] d);
    sptr = p; sfull = f; sempty = e; pdata = d;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      tick();
    end
  endtask

  always @(negedge clk) begin
    if (!areset && (push_en || pop_en || rbk_en)) begin
      vectors++;
      ev_idx++;
      if (sbq.size() == 0) begin
        miscompares++;
        $display("FAIL sb_unexpected#%0d: push=%0b pop=%0b rbk=%0b while no event expected",
                 ev_idx, push_en, pop_en, rbk_en);
      end else begin
        mexp = sbq.pop_front();
        if (push_en !== mexp.push || (mexp.push && push_data !== mexp.pdat) ||
            pop_en !== mexp.pop || pred_valid !== mexp.pop ||
            (mexp.pop && pred_target !== mexp.tgt) || rbk_en !== mexp.rbk ||
            (mexp.rbk && (rbk_ptr !== mexp.rptr || rbk_full !== mexp.rfull)) ||
            rbk_incr !== 1'b0 || spec_state !== mexp.spec) begin
          miscompares++;
          $display("FAIL sb_event#%0d: got push=%0b/%h pop=%0b pv=%0b/%h rbk=%0b/%0d/%0b spec=%b, expected push=%0b/%h pop=%0b/%h rbk=%0b/%0d/%0b spec=%b",
                   ev_idx, push_en, push_data, pop_en, pred_valid, pred_target, rbk_en, rbk_ptr,
                   rbk_full, spec_state, mexp.push, mexp.pdat, mexp.pop, mexp.tgt, mexp.rbk,
                   mexp.rptr, mexp.rfull, mexp.spec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench exceeded its time budget");
    $fatal(1);
  end

  initial begin
    // Reset held with a live CALL and flush at the inputs: everything must read 0.
    areset = 1'b1;
    stack(3'd0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    drive(1'b1, JAL_X1, 32'h100, 1'b0, 1'b1);
    chk("rst_push_en", {31'h0, push_en}, 32'h0);
    chk("rst_push_data", push_data, 32'h0);
    chk("rst_pop_en", {31'h0, pop_en}, 32'h0);
    chk("rst_pred_valid", {31'h0, pred_valid}, 32'h0);
    chk("rst_pred_target", pred_target, 32'h0);
    chk("rst_rbk_en", {31'h0, rbk_en}, 32'h0);
    chk("rst_rbk_incr", {31'h0, rbk_incr}, 32'h0);
    chk("rst_spec_state", {30'h0, spec_state}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    areset = 1'b0;

    // Basic CALL push, RET pop, RET on empty, then rollback of two RETs.
    stack(3'd0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, JAL_X1, 32'h100, 1'b0, 1'b0);
    exp_push(32'h104, 2'b00);
    tick();
    stack(3'd1, 1'b0, 1'b0, 32'h104);
    drive(1'b1, RET_X1, 32'h104, 1'b0, 1'b0);
    exp_pop(32'h104, 2'b01);
    tick();
    stack(3'd0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, RET_X1, 32'h108, 1'b0, 1'b0);
    chk("ret_empty_pop_en", {31'h0, pop_en}, 32'h0);
    chk("ret_empty_pred_valid", {31'h0, pred_valid}, 32'h0);
    chk("spec_call_ret", {30'h0, spec_state}, 32'h1);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    exp_rbk(3'd1, 1'b0, 2'b00);
    tick();
    idle(2);

    // Classification corners: x0 link, non-jump, x5 link, link-to-link JALR.
    stack(3'd0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, JAL_X0, 32'h1000, 1'b0, 1'b0);
    chk("jal_x0_push_en", {31'h0, push_en}, 32'h0);
    tick();
    drive(1'b1, ADDI_X1, 32'h1004, 1'b0, 1'b0);
    chk("addi_push_en", {31'h0, push_en}, 32'h0);
    chk("addi_pop_en", {31'h0, pop_en}, 32'h0);
    tick();
    drive(1'b1, JALR_X5X1, 32'h2000, 1'b0, 1'b0);
    exp_push(32'h2004, 2'b00);
    tick();
    stack(3'd1, 1'b0, 1'b0, 32'h2004);
    drive(1'b1, RET_X5, 32'h3000, 1'b0, 1'b0);
    exp_pop(32'h2004, 2'b01);
    tick();
    stack(3'd0, 1'b0, 1'b1, 32'h0);
    drive(1'b1, JALR_X1X1, 32'h3000, 1'b0, 1'b0);
    exp_push(32'h3004, 2'b01);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("spec_ret_call_noflush", {30'h0, spec_state}, 32'h3);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("spec_call_shifted", {30'h0, spec_state}, 32'h1);
    tick();

    // {CALL,CALL} rollback, flush with a valid FU instr, flush inside blackout.
    stack(3'd3, 1'b0, 1'b0, 32'h0);
    drive(1'b1, JAL_X1, 32'h400, 1'b0, 1'b0);
    exp_push(32'h404, 2'b00);
    tick();
    stack(3'd4, 1'b0, 1'b0, 32'h0);
    drive(1'b1, JAL_X1, 32'h500, 1'b0, 1'b0);
    exp_push(32'h504, 2'b01);
    tick();
    stack(3'd5, 1'b0, 1'b0, 32'h0);
    drive(1'b1, JAL_X1, 32'h600, 1'b0, 1'b1);
    exp_rbk(3'd3, 1'b0, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    chk("flush_in_blackout_rbk_en", {31'h0, rbk_en}, 32'h0);
    tick();
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, JAL_X1, 32'h700, 1'b0, 1'b0);
      chk("blackout_push_en", {31'h0, push_en}, 32'h0);
      tick();
    end
    drive(1'b1, JAL_X1, 32'h700, 1'b0, 1'b0);
    exp_push(32'h704, 2'b00);
    tick();
    idle(2);

    // {RET,CALL} rollback while stalled, then a stalled CALL pushes exactly once.
    stack(3'd5, 1'b0, 1'b0, 32'h804);
    drive(1'b1, RET_X1, 32'h800, 1'b0, 1'b0);
    exp_pop(32'h804, 2'b00);
    tick();
    stack(3'd4, 1'b0, 1'b0, 32'h0);
    drive(1'b1, JAL_X1, 32'h900, 1'b0, 1'b0);
    exp_push(32'h904, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    exp_rbk(3'd5, 1'b0, 2'b11);
    tick();
    idle(2);
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, JAL_X1, 32'hA00, 1'b1, 1'b0);
      chk("stalled_push_en", {31'h0, push_en}, 32'h0);
      tick();
    end
    drive(1'b1, JAL_X1, 32'hA00, 1'b0, 1'b0);
    exp_push(32'hA04, 2'b00);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("stall_holds_slot", {30'h0, spec_state}, 32'h1);
    tick();
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("slots_drained", {30'h0, spec_state}, 32'h0);
    tick();

    // Nine pushes from empty (wrap), rollback restores full=1, reset kills blackout.
    for (int i = 0; i < 8; i++) begin
      stack(3'(i), 1'b0, (i == 0), 32'h0);
      drive(1'b1, JAL_X1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0);
      exp_push(32'h1004 + 32'(4 * i), (i == 0) ? 2'b00 : (i == 1) ? 2'b01 : 2'b10);
      tick();
    end
    stack(3'd0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, JAL_X1, 32'h1020, 1'b0, 1'b0);
    exp_push(32'h1024, 2'b10);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    chk("spec_call_call", {30'h0, spec_state}, 32'h2);
    tick();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    exp_rbk(3'd0, 1'b1, 2'b01);
    tick();
    areset = 1'b1;
    stack(3'd0, 1'b0, 1'b1, 32'h55);
    drive(1'b1, JAL_X1, 32'h1100, 1'b0, 1'b0);
    chk("midrst_push_en", {31'h0, push_en}, 32'h0);
    chk("midrst_push_data", push_data, 32'h0);
    chk("midrst_pred_target", pred_target, 32'h0);
    chk("midrst_rbk_en", {31'h0, rbk_en}, 32'h0);
    chk("midrst_spec_state", {30'h0, spec_state}, 32'h0);
    tick();
    areset = 1'b0;
    drive(1'b1, JAL_X1, 32'h1100, 1'b0, 1'b0);
    exp_push(32'h1104, 2'b00);
    tick();
    idle(2);

    while (sbq.size() != 0) begin
      mexp = sbq.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL sb_missing: expected event push=%0b pop=%0b rbk=%0b never appeared",
               mexp.push, mexp.pop, mexp.rbk);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
